// File: rtl/sprite_mem_arb.sv
// Sprite attribute memory arbiter.
// Shares one single-port block RAM between the CPU EX stage and the sprite
// render engine, builds {sprite, attr} addresses, stalls the CPU while it is
// waiting, and runs the multi-cycle CLEAR action as a burst of zero writes.
module sprite_mem_arb #(
  parameter int SPR_AW   = 8,
  parameter int ATTR_W   = 4,
  parameter int DATA_W   = 14,
  parameter int CLR_LAST = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_re,
  input  logic                     cpu_we,
  input  logic [SPR_AW-1:0]        cpu_sprite_addr,
  input  logic [ATTR_W-1:0]        cpu_action,
  input  logic [DATA_W-1:0]        cpu_wdata,
  output logic                     cpu_stall,
  output logic                     cpu_rvalid,
  output logic [31:0]              cpu_rdata,
  input  logic                     rnd_req,
  input  logic [SPR_AW+ATTR_W-1:0] rnd_addr,
  output logic                     rnd_gnt,
  output logic                     rnd_rvalid,
  output logic [DATA_W-1:0]        rnd_rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [SPR_AW+ATTR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int AW = SPR_AW + ATTR_W;
  localparam logic [ATTR_W-1:0] ACT_CLR = '1;
  localparam logic [ATTR_W-1:0] CLR_END = ATTR_W'(CLR_LAST);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  logic                r_last_cpu;   // 1: CPU held the most recent grant
  logic [ATTR_W-1:0]   r_clr_cnt;
  logic                r_vld_cpu_p1;
  logic                r_zero_p1;    // pending CPU read was a CLEAR-slot read
  logic                r_vld_rnd_p1;
  logic [31:0]         r_cpu_rdata;

  logic                w_cpu_req;
  logic                w_cpu_win;
  logic                w_rnd_win;
  logic                w_cpu_rd;
  logic                w_clr_start;
  logic                w_en;
  logic                w_we;
  logic [AW-1:0]       w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_stall;
  logic [31:0]         w_cpu_rdata_now;

  // Arbitration and memory command for the current cycle (all quiet in reset)
  always_comb begin
    w_cpu_req   = cpu_re | cpu_we;
    w_cpu_win   = 1'b0;
    w_rnd_win   = 1'b0;
    w_cpu_rd    = 1'b0;
    w_clr_start = 1'b0;
    w_en        = 1'b0;
    w_we        = 1'b0;
    w_addr      = '0;
    w_wdata     = '0;
    w_stall     = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          // On a tie the requester that did not win last time gets the slot
          w_cpu_win = w_cpu_req & (~rnd_req | ~r_last_cpu);
          w_rnd_win = rnd_req & ~w_cpu_win;
          if (w_cpu_win) begin
            if (cpu_we) begin
              w_en = 1'b1;
              w_we = 1'b1;
              if (cpu_action == ACT_CLR) begin
                // First CLEAR write goes out in the grant cycle itself
                w_addr      = {cpu_sprite_addr, {ATTR_W{1'b0}}};
                w_stall     = 1'b1;
                w_clr_start = 1'b1;
              end else begin
                w_addr  = {cpu_sprite_addr, cpu_action};
                w_wdata = cpu_wdata;
              end
            end else begin
              // A read of the CLEAR slot touches no memory but still answers
              w_cpu_rd = 1'b1;
              if (cpu_action != ACT_CLR) begin
                w_en   = 1'b1;
                w_addr = {cpu_sprite_addr, cpu_action};
              end
            end
          end else if (w_rnd_win) begin
            w_en    = 1'b1;
            w_addr  = rnd_addr;
            w_stall = w_cpu_req;
          end
        end
        S_CLEAR: begin
          w_en    = 1'b1;
          w_we    = 1'b1;
          w_addr  = {cpu_sprite_addr, r_clr_cnt};
          w_stall = (r_clr_cnt != CLR_END);
        end
        default: ;
      endcase
    end
  end

  // Control FSM: grant history and CLEAR sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last_cpu <= 1'b1;
      r_clr_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cpu_win) r_last_cpu <= 1'b1;
          if (w_rnd_win) r_last_cpu <= 1'b0;
          if (w_clr_start) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= ATTR_W'(1);
          end
        end
        S_CLEAR: begin
          if (r_clr_cnt == CLR_END) begin
            r_state   <= S_IDLE;
            r_clr_cnt <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + ATTR_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ---- stage p0 -> p1: read issued, data returns from RAM next cycle ----
  assign w_cpu_rdata_now = r_zero_p1 ? 32'd0 : {{(32-DATA_W){1'b0}}, mem_rdata};

  // Track which port owns the read in flight and hold the last CPU read value
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_cpu_p1 <= 1'b0;
      r_zero_p1    <= 1'b0;
      r_vld_rnd_p1 <= 1'b0;
      r_cpu_rdata  <= '0;
    end else begin
      r_vld_cpu_p1 <= w_cpu_rd;
      r_zero_p1    <= w_cpu_rd & (cpu_action == ACT_CLR);
      r_vld_rnd_p1 <= w_rnd_win;
      if (r_vld_cpu_p1) r_cpu_rdata <= w_cpu_rdata_now;
    end
  end

  assign mem_en     = w_en;
  assign mem_we     = w_we;
  assign mem_addr   = w_addr;
  assign mem_wdata  = w_wdata;
  assign cpu_stall  = w_stall;
  assign rnd_gnt    = w_rnd_win;
  assign cpu_rvalid = r_vld_cpu_p1 & ~rst;
  assign cpu_rdata  = rst ? 32'd0 : (r_vld_cpu_p1 ? w_cpu_rdata_now : r_cpu_rdata);
  assign rnd_rvalid = r_vld_rnd_p1 & ~rst;
  assign rnd_rdata  = rnd_rvalid ? mem_rdata : '0;

endmodule
